pc_sequencer: RTL and testbench

Next-PC controller for the IF stage of the pipelined core. It selects the next fetch address from sequential, jump (ID), branch (EX) and exception/return sources, and drives the PC register's write enable. It holds redirects that arrive while instruction memory is busy and raises IF/ID and ID/EX flushes. It sits between the hazard/branch logic and the PC register, whose `NPC`/`PCWrite` inputs it owns.

---
 rtl/pcseq_pkg.sv | 24 ++
 rtl/pcseq_prio.sv | 46 ++++
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pcseq_pkg.sv
// Shared types and defaults for the IF-stage next-PC sequencer.
package pcseq_pkg;

  typedef logic [31:2] word_addr_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Encoded in ascending priority so a held redirect can be compared with '>'.
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_JMP  = 3'd1,
    SRC_BR   = 3'd2,
    SRC_ERET = 3'd3,
    SRC_EXC  = 3'd4
  } src_t;

  localparam word_addr_t DEF_START_ADDR = 30'h0000BFF;
  localparam word_addr_t DEF_EXC_VECTOR = 30'h0000C00;

endpackage

// File: rtl/pcseq_prio.sv
// Priority encoder and target mux for next-PC sources.
// Exception/eret levels exist only when PCSEQ_EXC_EN is defined.
module pcseq_prio
  import pcseq_pkg::*;
#(
  parameter word_addr_t EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:2] pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:2] epc,
  input  logic        branch_req,
  input  logic [31:2] branch_target,
  input  logic        jump_req,
  input  logic [31:2] jump_target,
  output src_t        src,
  output logic [31:2] target
);

  always_comb begin
    src    = SRC_SEQ;
    target = pc + 30'd1;
`ifdef PCSEQ_EXC_EN
    if (exc_req) begin
      src    = SRC_EXC;
      target = EXC_VECTOR;
    end else if (eret_req) begin
      src    = SRC_ERET;
      target = epc;
    end else
`endif
    if (branch_req) begin
      src    = SRC_BR;
      target = branch_target;
    end else if (jump_req) begin
      src    = SRC_JMP;
      target = jump_target;
    end
  end

`ifndef PCSEQ_EXC_EN
  logic unused_exc;
  assign unused_exc = ^{exc_req, eret_req, epc, EXC_VECTOR};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the IF stage: source select, redirect holding, flushes.
// Optional exception/eret sources are enabled with PCSEQ_EXC_EN.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter word_addr_t START_ADDR = DEF_START_ADDR,
  parameter word_addr_t EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] pc,
  input  logic        imem_ready,
  input  logic        stall_req,
  input  logic        jump_req,
  input  logic [31:2] jump_target,
  input  logic        branch_req,
  input  logic [31:2] branch_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:2] epc,
  output logic [31:2] npc,
  output logic        pc_write,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        redirect_pending,
  output logic [31:0] stall_cycles
);

  state_t      state, state_next;
  word_addr_t  pend_pc;
  src_t        pend_src;
  src_t        sel_src;
  word_addr_t  sel_target;
  logic        pend_load;

  pcseq_prio #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_prio (
    .pc            (pc),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .src           (sel_src),
    .target        (sel_target)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= BOOT;
      pend_pc      <= '0;
      pend_src     <= SRC_SEQ;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      if (pend_load) begin
        pend_pc  <= sel_target;
        pend_src <= sel_src;
      end
      if (state != BOOT && !pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  always_comb begin
    state_next       = state;
    npc              = pc;
    pc_write         = 1'b0;
    flush_ifid       = 1'b0;
    flush_idex       = 1'b0;
    redirect_pending = 1'b0;
    pend_load        = 1'b0;
    unique case (state)
      BOOT: begin
        npc        = START_ADDR;
        state_next = RUN;
      end
      RUN: begin
        if (sel_src != SRC_SEQ) begin
          // Redirect beats stall: the stalled instruction is flushed anyway.
          npc        = sel_target;
          flush_ifid = 1'b1;
          flush_idex = (sel_src != SRC_JMP);
          if (imem_ready) begin
            pc_write = 1'b1;
          end else begin
            pend_load  = 1'b1;
            state_next = PEND;
          end
        end else if (!stall_req && imem_ready) begin
          npc      = sel_target;
          pc_write = 1'b1;
        end
      end
      PEND: begin
        redirect_pending = 1'b1;
        pc_write         = imem_ready;
        npc              = pend_pc;
        // Only a strictly higher-priority source replaces the held target.
        if (sel_src > pend_src) begin
          npc        = sel_target;
          flush_ifid = 1'b1;
          flush_idex = (sel_src != SRC_JMP);
          pend_load  = !imem_ready;
        end
        if (imem_ready)
          state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (both PCSEQ_EXC_EN builds).
module tb_pc_sequencer;
  import pcseq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] pc;
  logic        imem_ready, stall_req;
  logic        jump_req, branch_req, exc_req, eret_req;
  logic [31:2] jump_target, branch_target, epc;
  logic [31:2] npc;
  logic        pc_write, flush_ifid, flush_idex, redirect_pending;
  logic [31:0] stall_cycles;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .pc               (pc),
    .imem_ready       (imem_ready),
    .stall_req        (stall_req),
    .jump_req         (jump_req),
    .jump_target      (jump_target),
    .branch_req       (branch_req),
    .branch_target    (branch_target),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .npc              (npc),
    .pc_write         (pc_write),
    .flush_ifid       (flush_ifid),
    .flush_idex       (flush_idex),
    .redirect_pending (redirect_pending),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_req = 1'b0; jump_req = 1'b0; branch_req = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; pc = '0; imem_ready = 1'b1; idle();
    jump_target = '0; branch_target = '0; epc = '0;
    repeat (3) tick();
    chk("rst_npc", 32'(npc), 32'h0BFF);
    chk("rst_pcw", 32'(pc_write), 0);
    chk("rst_flush", 32'({flush_ifid, flush_idex}), 0);
    chk("rst_pend", 32'(redirect_pending), 0);
    chk("rst_stall", stall_cycles, 0);

    // Boot cycle then first sequential fetch
    reset = 1'b1; pc = 30'h0BFF; #1;
    chk("boot_npc", 32'(npc), 32'h0BFF);
    chk("boot_pcw", 32'(pc_write), 0);
    tick();
    chk("run1_npc", 32'(npc), 32'h0C00);
    chk("run1_pcw", 32'(pc_write), 1);
    tick();

    // Branch beats simultaneous jump
    pc = 30'h100; branch_req = 1'b1; branch_target = 30'h200;
    jump_req = 1'b1; jump_target = 30'h300; #1;
    chk("bj_npc", 32'(npc), 32'h200);
    chk("bj_flush", 32'({flush_ifid, flush_idex}), 32'h3);
    chk("bj_pcw", 32'(pc_write), 1);
    tick(); idle();

    // Jump held while imem busy
    pc = 30'h200; jump_req = 1'b1; jump_target = 30'h40; imem_ready = 1'b0; #1;
    chk("jh_pcw0", 32'(pc_write), 0);
    chk("jh_flush", 32'({flush_ifid, flush_idex}), 32'h2);
    chk("jh_pend0", 32'(redirect_pending), 0);
    tick(); idle(); stall_req = 1'b1;
    chk("jh_pend1", 32'({redirect_pending, pc_write}), 32'h2);
    chk("jh_npc1", 32'(npc), 32'h40);
    tick();
    chk("jh_pend2", 32'({redirect_pending, pc_write}), 32'h2);
    tick(); imem_ready = 1'b1; #1;
    chk("jh_pend3", 32'({redirect_pending, pc_write}), 32'h3);
    chk("jh_npc3", 32'(npc), 32'h40);
    chk("jh_stall", stall_cycles, 3);
    tick(); stall_req = 1'b0; pc = 30'h40; #1;
    chk("jh_after", 32'({redirect_pending, pc_write}), 32'h1);
    chk("jh_seq", 32'(npc), 32'h41);
    tick();

    // Held branch, then higher/lower priority requests in PEND
    pc = 30'h41; branch_req = 1'b1; branch_target = 30'h80; imem_ready = 1'b0; #1;
    chk("bh_flush", 32'({flush_ifid, flush_idex}), 32'h3);
    tick(); idle();
`ifdef PCSEQ_EXC_EN
    exc_req = 1'b1; #1;
    chk("exo_npc", 32'(npc), 32'h0C00);
    chk("exo_flush", 32'({flush_ifid, flush_idex}), 32'h3);
    tick(); idle();
    jump_req = 1'b1; jump_target = 30'h300; #1;
    chk("exo_jmp_npc", 32'(npc), 32'h0C00);
    chk("exo_jmp_flush", 32'({flush_ifid, flush_idex}), 0);
    tick(); idle(); imem_ready = 1'b1; #1;
    chk("exo_rel", 32'(npc), 32'h0C00);
    chk("exo_rel_pcw", 32'(pc_write), 1);
    tick();
    pc = 30'h0C00; eret_req = 1'b1; epc = 30'h55; branch_req = 1'b1; branch_target = 30'h99; #1;
    chk("eret_npc", 32'(npc), 32'h55);
    tick(); idle();
`else
    exc_req = 1'b1; epc = 30'h55; #1;
    chk("nexc_npc", 32'(npc), 32'h80);
    chk("nexc_flush", 32'({flush_ifid, flush_idex}), 0);
    tick(); idle();
    jump_req = 1'b1; jump_target = 30'h300; #1;
    chk("nexc_jmp_npc", 32'(npc), 32'h80);
    chk("nexc_jmp_flush", 32'({flush_ifid, flush_idex}), 0);
    tick(); idle(); imem_ready = 1'b1; #1;
    chk("nexc_rel", 32'(npc), 32'h80);
    chk("nexc_rel_pcw", 32'(pc_write), 1);
    tick();
    pc = 30'h80; exc_req = 1'b1; eret_req = 1'b1; #1;
    chk("nexc_run_npc", 32'(npc), 32'h81);
    chk("nexc_run_flush", 32'({flush_ifid, flush_idex}), 0);
    tick(); idle();
`endif
    chk("held_stall", stall_cycles, 6);

    // Stall two cycles, then stall plus branch
    pc = 30'h50; stall_req = 1'b1; #1;
    chk("st1_pcw", 32'(pc_write), 0);
    tick();
    chk("st2_pcw", 32'(pc_write), 0);
    tick(); branch_req = 1'b1; branch_target = 30'h90; #1;
    chk("stbr_pcw", 32'(pc_write), 1);
    chk("stbr_npc", 32'(npc), 32'h90);
    chk("stbr_flush", 32'({flush_ifid, flush_idex}), 32'h3);
    tick(); idle();
    chk("st_cnt", stall_cycles, 8);

    // Sequential wrap
    pc = 30'h3FFFFFFF; #1;
    chk("wrap_npc", 32'(npc), 0);
    chk("wrap_pcw", 32'(pc_write), 1);
    tick();

    // Reset mid-PEND drops the held target
    pc = 30'h10; branch_req = 1'b1; branch_target = 30'h123; imem_ready = 1'b0;
    tick(); idle();
    chk("rp_pend", 32'(redirect_pending), 1);
    reset = 1'b0; tick();
    chk("rp_npc", 32'(npc), 32'h0BFF);
    chk("rp_pend0", 32'(redirect_pending), 0);
    chk("rp_stall", stall_cycles, 0);
    reset = 1'b1; imem_ready = 1'b1; pc = 30'h0BFF;
    tick(); #1;
    chk("rp_run_npc", 32'(npc), 32'h0C00);
    chk("rp_run_pend", 32'({redirect_pending, pc_write}), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
